// File: rtl/unary_prefix_encoder.sv
// unary_prefix_encoder: packs counts as n ones plus a zero terminator, MSB-first, into W-bit words.
// Define UPE_FLUSH_EN to add the flush_req port for emitting zero-padded partial words.
module unary_prefix_encoder #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] in_count,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  out_word,
    output logic          out_valid,
    input  logic          out_ready
`ifdef UPE_FLUSH_EN
    ,
    input  logic          flush_req
`endif
);
    localparam int FW = $clog2(W);
    localparam int SW = (CW > FW + 1) ? CW : FW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [W-1:0]  pack;
    logic [FW-1:0] fill;
    logic [CW-1:0] r;
    logic [CW-1:0] r_cur;
    logic [SW-1:0] rx, sp, nf;
    logic [W-1:0]  nbuf;
    logic          blocked, fits, complete, go, flush;

    assign blocked  = out_valid && !out_ready;
    assign in_ready = (state == IDLE) && !blocked;
    assign r_cur    = (state == IDLE) ? in_count : r;
    assign rx       = SW'(r_cur);
    assign sp       = SW'(W) - SW'(fill);
    assign fits     = rx < sp;
    assign nf       = SW'(fill) + rx + SW'(1);
    // Top r_cur ones (or a full run) shifted down to the current fill point.
    assign nbuf     = pack | (fits ? ((~({W{1'b1}} >> r_cur)) >> fill) : ({W{1'b1}} >> fill));
    assign complete = !fits || (nf == SW'(W));
    assign go       = ((state == RUN) || (in_valid && in_ready)) && !(complete && blocked);

`ifdef UPE_FLUSH_EN
    assign flush = (state == IDLE) && !in_valid && (fill != '0) && flush_req && !blocked;
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pack      <= '0;
            fill      <= '0;
            r         <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
        end else begin
            if ((go && complete) || flush) begin
                out_word  <= go ? nbuf : pack;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (go) begin
                pack  <= complete ? '0 : nbuf;
                fill  <= complete ? '0 : FW'(nf);
                r     <= fits ? '0 : CW'(rx - sp);
                state <= fits ? IDLE : RUN;
            end else if (flush) begin
                pack <= '0;
                fill <= '0;
            end
        end
    end
endmodule

// File: tb/tb_unary_prefix_encoder.sv
// tb_unary_prefix_encoder: directed vectors with hand-computed words for unary_prefix_encoder (W=8, CW=8).
module tb_unary_prefix_encoder;
    logic       clk;
    logic       rst_n;
    logic [7:0] in_count;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_word;
    logic       out_valid;
    logic       out_ready;
`ifdef UPE_FLUSH_EN
    logic       flush_req;
`endif
    int n_cmp = 0;
    int n_err = 0;

    unary_prefix_encoder #(.W(8), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_count  (in_count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef UPE_FLUSH_EN
        ,
        .flush_req (flush_req)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        in_valid = 1'b1;
        in_count = c;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_chk(input string tag, input logic [7:0] c);
        in_valid = 1'b1;
        in_count = c;
        #1 check(tag, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

`ifdef UPE_FLUSH_EN
    task automatic do_flush;
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_count = '0; out_ready = 1'b1;
`ifdef UPE_FLUSH_EN
        flush_req = 1'b0;
`endif
        #12;
        check("rst_ovalid", out_valid, 0);
        check("rst_oword", out_word, 0);
        check("rst_irdy", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // 2,0,3 back to back -> 110 0 1110 = 0xCE
        send_chk("t1_rdy_a", 2);
        check("t1_ov_a", out_valid, 0);
        send_chk("t1_rdy_b", 0);
        check("t1_ov_b", out_valid, 0);
        send_chk("t1_rdy_c", 3);
        check("t1_ov_c", out_valid, 1);
        check("t1_word", out_word, 8'hCE);
        @(negedge clk);
        check("t1_ov_d", out_valid, 0);

        // count 19 -> FF, FF, then 1110 left with fill=4
        send(19);
        check("t2_ov_a", out_valid, 1);
        check("t2_w_a", out_word, 8'hFF);
        check("t2_rdy_a", in_ready, 0);
        @(negedge clk);
        check("t2_ov_b", out_valid, 1);
        check("t2_w_b", out_word, 8'hFF);
        check("t2_rdy_b", in_ready, 0);
        @(negedge clk);
        check("t2_ov_c", out_valid, 0);
        check("t2_rdy_c", in_ready, 1);
`ifdef UPE_FLUSH_EN
        do_flush();
        check("t2_fl_ov", out_valid, 1);
        check("t2_fl_w", out_word, 8'hE0);
`else
        send(3);
        check("t2_tail_ov", out_valid, 1);
        check("t2_tail_w", out_word, 8'hEE);
`endif
        @(negedge clk);

        // eight zero counts -> one 0x00 word
        for (int i = 0; i < 8; i++) begin
            send_chk($sformatf("t3_rdy%0d", i), 0);
            check($sformatf("t3_ov%0d", i), out_valid, (i == 7) ? 1 : 0);
        end
        check("t3_word", out_word, 8'h00);
        @(negedge clk);

        // backpressure: FE pending, count 9 offered while blocked
        out_ready = 1'b0;
        send(7);
        check("t4_ov_a", out_valid, 1);
        check("t4_w_a", out_word, 8'hFE);
        in_valid = 1'b1;
        in_count = 9;
        for (int i = 0; i < 5; i++) begin
            #1 check($sformatf("t4_rdy%0d", i), in_ready, 0);
            @(negedge clk);
            check($sformatf("t4_hold%0d", i), out_word, 8'hFE);
            check($sformatf("t4_hov%0d", i), out_valid, 1);
        end
        out_ready = 1'b1;
        #1 check("t4_rdy_rel", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("t4_ov_b", out_valid, 1);
        check("t4_w_b", out_word, 8'hFF);
        @(negedge clk);
        check("t4_ov_c", out_valid, 0);
        check("t4_rdy_c", in_ready, 1);
        send(5);
        check("t4_ov_d", out_valid, 1);
        check("t4_w_d", out_word, 8'hBE);
        @(negedge clk);

        // asynchronous reset mid-RUN of count 20
        send(20);
        check("t5_ov_a", out_valid, 1);
        check("t5_rdy_a", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_ov_rst", out_valid, 0);
        check("t5_w_rst", out_word, 0);
        check("t5_rdy_rst", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        send(1);
        check("t5_ov_b", out_valid, 0);
`ifdef UPE_FLUSH_EN
        do_flush();
        check("t5_ov_c", out_valid, 1);
        check("t5_w_c", out_word, 8'h80);
`else
        send(5);
        check("t5_ov_c", out_valid, 1);
        check("t5_w_c", out_word, 8'hBE);
`endif
        @(negedge clk);

`ifdef UPE_FLUSH_EN
        do_flush();
        check("t6_empty_ov", out_valid, 0);
        send(1);
        send(0);
        check("t6_ov_a", out_valid, 0);
        do_flush();
        check("t6_ov_b", out_valid, 1);
        check("t6_w_b", out_word, 8'h80);
        @(negedge clk);
        flush_req = 1'b1;
        send(1);
        check("t6_defer_ov", out_valid, 0);
        @(negedge clk);
        flush_req = 1'b0;
        check("t6_ov_c", out_valid, 1);
        check("t6_w_c", out_word, 8'h80);
        @(negedge clk);
        check("t6_ov_d", out_valid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/unary_prefix_encoder.md
# unary_prefix_encoder

Packs a stream of small unsigned counts into a unary-prefix bitstream. Each count n becomes n one-bits followed by a single zero terminator. The bits are packed MSB-first into W-bit words and delivered over a valid/ready interface. This is the transmit-side counterpart of the leading-one counter: a downstream decoder applies count_lead_one to each word to recover n, and treats a result of W (all ones) as "continues in the next word".

## Interface
- W, 8: output word width in bits; power of two, ≥ 2.
- CW, 8: input count width in bits; counts range over 0 .. 2^CW−1.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_count  input  CW  count n of the offered symbol.
- in_valid  input  1  in_count is valid.
- in_ready  output  1  symbol accepted when in_valid && in_ready at the clock edge.
- flush_req  input  1  level request to emit a partial word padded with zeros (present only with UPE_FLUSH_EN).
- out_word  output  W  packed word; the first bit in the stream is at bit W−1.
- out_valid  output  1  out_word is valid.
- out_ready  input  1  word consumed when out_valid && out_ready at the clock edge.

## Operation
- Internal state:
  - pack buffer buf[W−1:0];
  - fill 0..W−1, the number of bits already packed, taken from the MSB side;
  - remaining-ones register r (CW bits);
  - FSM state IDLE or RUN.
- Output register: out_word/out_valid. Once loaded, it holds its value until out_ready is sampled high.
- blocked = out_valid && !out_ready.
- Step: place bits at buf positions W−1−fill downward, with space = W − fill.
  - If pending ones r < space: place r ones, then the 0 terminator. fill += r+1. The symbol is done.
  - Else: place space ones. r −= space. The word completes and the symbol is not done.
  - If fill reaches W, the word completes.
- Word completion: buf (with any unplaced low bits at 0) is loaded into the output register. buf and fill are cleared.
  - A step that would complete a word while blocked is not executed. All state holds.
- IDLE:
  - in_ready = !blocked. This must not depend on in_valid.
  - On acceptance, the first step runs in the same cycle with r = in_count.
  - If the symbol is done, stay in IDLE. Otherwise go to RUN.
- RUN:
  - in_ready = 0.
  - One step per non-stalled cycle.
  - Return to IDLE in the cycle the terminator is placed.
- Count 0 emits the single bit "0".
- Count ≥ W emits one or more all-ones words, then the remainder.
- Simultaneous word completion and out_ready: the old word is consumed and the new word is loaded in the same edge. No bubble.
- Reset (asynchronous, any state including mid-RUN):
  - state = IDLE; buf = 0; fill = 0; r = 0.
  - out_valid = 0; out_word = 0.
  - in_ready = 1 as soon as reset deasserts (out_valid is 0).
  - A partially sent symbol is discarded.

## Timing
- A word completed at edge t is presented with out_valid = 1 from t+1 onward.
- Throughput:
  - One symbol per cycle while each symbol fits in the remaining space and the output is not blocked.
  - A symbol of count n spanning k words occupies k cycles.
- out_word and out_valid are registered. in_ready is combinational from state and out_valid/out_ready only.
- Combinational depth is one step. The implementation needs a shifter to place r ones within W bits, so no barrel shift chain longer than W is allowed.

## Configuration
- UPE_FLUSH_EN defined:
  - The flush_req port exists.
  - When state = IDLE, in_valid = 0, fill > 0, flush_req = 1 and not blocked, buf is emitted as a completed word (unused low bits 0) and fill is cleared.
  - flush_req with fill = 0 is a no-op.
  - in_valid has priority over flush_req in the same cycle.
- UPE_FLUSH_EN undefined:
  - No flush_req port.
  - Partial words are emitted only when filled.
  - All other behaviour is identical.

## Test plan
- W=8, counts 2, 0, 3 in consecutive cycles, out_ready=1:
  - in_ready stays high.
  - Exactly one word, 0xCE, appears one cycle after the third accept.
- Count 19 from empty, out_ready=1:
  - FSM goes to RUN.
  - Words 0xFF, 0xFF are emitted on consecutive cycles.
  - fill = 4 is left over; with UPE_FLUSH_EN, flush_req then yields 0xE0.
- Count 0 eight times in a row:
  - One word, 0x00, is emitted.
  - in_ready is never low while out_ready=1.
- Backpressure: hold out_ready=0 for 5 cycles while a word is pending, and offer a symbol that completes another word:
  - out_word is stable and in_ready=0 throughout.
  - When out_ready rises, the pending word transfers and the next word appears the following cycle.
- Assert rst_n low mid-RUN, partway through count 20:
  - out_valid=0 and out_word=0 immediately, asynchronously.
  - After release, count 1 followed by flush (UPE_FLUSH_EN) yields 0x80.
- UPE_FLUSH_EN:
  - flush_req with fill=0 emits no word.
  - Flush after count 1 plus count 0 (fill=3, "100") emits 0x80.
  - flush_req asserted together with in_valid defers the flush until the cycle after the symbol is accepted.
